// File: rtl/score_display_ctrl.sv
// Score display sequencer: captures both player scores, converts them to BCD with one
// shared double-dabble engine, and drives the digit nibbles plus blank/blink enables.
module score_display_ctrl #(
    parameter int SCORE_W   = 7,
    parameter int BLINK_DIV = 25000000
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score_p1,
    input  logic [SCORE_W-1:0] score_p2,
    input  logic               game_over,
    output logic               busy,
    output logic [15:0]        digits,
    output logic [3:0]         digit_en
);

    localparam int SR_W   = 8 + SCORE_W;
    localparam int ITER_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam int BC_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [ITER_W-1:0] ITER_LAST  = ITER_W'(SCORE_W - 1);
    localparam logic [BC_W-1:0]   BLINK_LAST = BC_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV_P1, CONV_P2, COMMIT} state_t;

    state_t              state_q, state_d;
    logic                pending_q, pending_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [15:0]         digits_q, digits_d;
    logic [3:0]          digit_en_q, digit_en_d;
    logic [BC_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                phase_on_q, phase_on_d;
    logic [SCORE_W-1:0]  pend_p1_q, pend_p1_d;
    logic [SCORE_W-1:0]  pend_p2_q, pend_p2_d;
    logic [SCORE_W-1:0]  p2_snap_q, p2_snap_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [7:0]          p1_bcd_q, p1_bcd_d;
    logic [SR_W-1:0]     dd_next;

    function automatic logic [SCORE_W-1:0] clamp99(input logic [SCORE_W-1:0] v);
        if (32'(v) >= 32'd100) return SCORE_W'(99);
        return v;
    endfunction

    // One double-dabble iteration: correct each BCD nibble, then shift left.
    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        if (t[SR_W-1 -: 4] >= 4'd5) t[SR_W-1 -: 4] = t[SR_W-1 -: 4] + 4'd3;
        if (t[SR_W-5 -: 4] >= 4'd5) t[SR_W-5 -: 4] = t[SR_W-5 -: 4] + 4'd3;
        return {t[SR_W-2:0], 1'b0};
    endfunction

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        iter_d      = iter_q;
        digits_d    = digits_q;
        blink_cnt_d = blink_cnt_q;
        phase_on_d  = phase_on_q;
        pend_p1_d   = pend_p1_q;
        pend_p2_d   = pend_p2_q;
        p2_snap_d   = p2_snap_q;
        sr_d        = sr_q;
        p1_bcd_d    = p1_bcd_q;
        dd_next     = dd_step(sr_q);

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    sr_d      = {8'h00, pend_p1_q};
                    p2_snap_d = pend_p2_q;
                    pending_d = 1'b0;
                    iter_d    = '0;
                    state_d   = CONV_P1;
                end
            end
            CONV_P1: begin
                sr_d   = dd_next;
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_LAST) begin
                    p1_bcd_d = dd_next[SR_W-1 -: 8];
                    sr_d     = {8'h00, p2_snap_q};
                    iter_d   = '0;
                    state_d  = CONV_P2;
                end
            end
            CONV_P2: begin
                sr_d   = dd_next;
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_LAST) begin
                    iter_d  = '0;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                digits_d = {p1_bcd_q, sr_q[SR_W-1 -: 8]};
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Capture after the FSM so a same-cycle strobe re-arms pending.
        if (score_valid) begin
            pend_p1_d = clamp99(score_p1);
            pend_p2_d = clamp99(score_p2);
            pending_d = 1'b1;
        end

        if (game_over) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_on_d  = ~phase_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end else begin
            blink_cnt_d = '0;
            phase_on_d  = 1'b1;
        end

        // Uses the next phase so releasing game_over restores the display in one edge.
        digit_en_d = phase_on_d ? {digits_q[15:12] != 4'd0, 1'b1, digits_q[7:4] != 4'd0, 1'b1}
                                : 4'b0000;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            iter_q      <= '0;
            digits_q    <= 16'h0000;
            digit_en_q  <= 4'b0101;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            iter_q      <= iter_d;
            digits_q    <= digits_d;
            digit_en_q  <= digit_en_d;
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
        end
    end

    // Datapath registers are qualified by the control state and need no reset.
    always_ff @(posedge clock) begin
        pend_p1_q <= pend_p1_d;
        pend_p2_q <= pend_p2_d;
        p2_snap_q <= p2_snap_d;
        sr_q      <= sr_d;
        p1_bcd_q  <= p1_bcd_d;
    end

    assign busy     = (state_q != IDLE);
    assign digits   = digits_q;
    assign digit_en = digit_en_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed and randomized checks of score_display_ctrl against an arithmetic
// model of the displayed score (clamp, decimal split, blanking, blink phase).
module tb_score_display_ctrl;

    localparam int SCORE_W   = 7;
    localparam int BLINK_DIV = 4;

    logic               clock;
    logic               resetn;
    logic               score_valid;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic               game_over;
    logic               busy;
    logic [15:0]        digits;
    logic [3:0]         digit_en;

    int total = 0;
    int bad   = 0;

    score_display_ctrl #(.SCORE_W(SCORE_W), .BLINK_DIV(BLINK_DIV)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .score_valid (score_valid),
        .score_p1    (score_p1),
        .score_p2    (score_p2),
        .game_over   (game_over),
        .busy        (busy),
        .digits      (digits),
        .digit_en    (digit_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int clampv(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    function automatic logic [15:0] exp_digits(input int a, input int b);
        int ca;
        int cb;
        ca = clampv(a);
        cb = clampv(b);
        return {4'(ca / 10), 4'(ca % 10), 4'(cb / 10), 4'(cb % 10)};
    endfunction

    function automatic logic [3:0] exp_en(input int a, input int b);
        return {(clampv(a) >= 10), 1'b1, (clampv(b) >= 10), 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input int a, input int b);
        score_p1    = SCORE_W'(a);
        score_p2    = SCORE_W'(b);
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
    endtask

    // Full conversion from an idle DUT: busy window, commit edge, enable edge.
    task automatic run_conv(input int a, input int b);
        strobe(a, b);
        chk("busy_at_strobe", busy, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("busy_conv", busy, 1'b1);
        end
        tick();
        chk("digits_commit", digits, exp_digits(a, b));
        chk("busy_commit", busy, 1'b0);
        tick();
        chk("digit_en_commit", digit_en, exp_en(a, b));
    endtask

    initial begin
        resetn      = 1'b0;
        score_valid = 1'b0;
        score_p1    = '0;
        score_p2    = '0;
        game_over   = 1'b0;
        tick();
        tick();
        resetn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_busy", busy, 1'b0);
            chk("idle_digits", digits, 16'h0000);
            chk("idle_en", digit_en, 4'b0101);
        end

        run_conv(42, 7);
        chk("val_4207", digits, 16'h4207);
        run_conv(127, 100);
        chk("val_9999", digits, 16'h9999);
        run_conv(9, 10);
        run_conv(0, 0);
        run_conv(99, 99);
        run_conv(100, 5);

        for (int r = 0; r < 8; r++) begin
            run_conv(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
        end

        // Back-to-back strobes: last writer wins, one IDLE cycle between conversions.
        strobe(5, 5);
        for (int i = 1; i <= 4; i++) tick();
        strobe(10, 3);
        strobe(11, 2);
        for (int i = 7; i <= 16; i++) tick();
        chk("b2b_first_digits", digits, 16'h0505);
        chk("b2b_first_busy", busy, 1'b0);
        tick();
        chk("b2b_second_start", busy, 1'b1);
        for (int i = 18; i <= 31; i++) tick();
        chk("b2b_no_partial", digits, 16'h0505);
        chk("b2b_still_busy", busy, 1'b1);
        tick();
        chk("b2b_second_digits", digits, 16'h1102);
        chk("b2b_second_busy", busy, 1'b0);
        tick();
        chk("b2b_second_en", digit_en, 4'b1101);

        // Blink: phase after n edges of game_over is ON when (n / BLINK_DIV) is even.
        run_conv(42, 7);
        game_over = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            chk("blink_en", digit_en, (((n / BLINK_DIV) % 2) == 0) ? 4'b1101 : 4'b0000);
        end
        game_over = 1'b0;
        tick();
        chk("blink_release", digit_en, 4'b1101);
        game_over = 1'b1;
        for (int n = 1; n <= BLINK_DIV; n++) begin
            tick();
            chk("blink_restart", digit_en, (((n / BLINK_DIV) % 2) == 0) ? 4'b1101 : 4'b0000);
        end
        game_over = 1'b0;
        tick();
        chk("blink_release2", digit_en, 4'b1101);

        // Reset in the middle of a conversion.
        strobe(88, 66);
        for (int i = 1; i <= 8; i++) tick();
        chk("pre_reset_busy", busy, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_digits", digits, 16'h0000);
        chk("rst_en", digit_en, 4'b0101);
        #3;
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_rst_busy", busy, 1'b0);
        end
        chk("post_rst_digits", digits, 16'h0000);
        chk("post_rst_en", digit_en, 4'b0101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
